out_scan_stats: RTL and testbench
=================================

Name: out_scan_stats

Overview:
Downstream stage of the sequential bilinear core. It sits on the read port of the output BRAM and scans the produced image once the core signals done. It computes pixel count, sum, min, max and a Fletcher-32 checksum, so the host can validate a run over JTAG without reading every pixel. Outside a scan, the read port passes straight through to the JTAG read address.

Parameters:
AW, 12, BRAM address width; max scannable pixels = 2^AW
HIST_CNT_W, 16, width of each histogram bin counter (only used with STATS_HIST_EN)

Ports:
clk_50  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse, driven by core done
i_out_w  in  16  output image width
i_out_h  in  16  output image height
jtag_raddr  in  AW  JTAG read address for the output BRAM
mem_raddr  out  AW  address driven to output BRAM read port
mem_rdata  in  8  BRAM read data, 1-cycle latency
o_port_busy  out  1  1 = BRAM port owned by scanner; JTAG data invalid
o_busy  out  1  scan in progress
o_done  out  1  one-cycle pulse when results are final
o_valid  out  1  level; results valid since last done
o_clamped  out  1  w*h exceeded 2^AW and was clamped
o_count  out  AW+1  pixels accumulated
o_sum  out  32  sum of pixels
o_min  out  8  minimum pixel
o_max  out  8  maximum pixel
o_csum  out  32  Fletcher-32 value {s2[15:0], s1[15:0]}
i_hist_sel  in  4  histogram bin select (STATS_HIST_EN only)
o_hist_bin  out  HIST_CNT_W  selected bin count (STATS_HIST_EN only)

Behaviour:
- Reset values: all outputs 0, except o_min=8'hFF. State IDLE. mem_raddr follows jtag_raddr.
- FSM states: IDLE, SCAN, DRAIN, DONE.
- IDLE, start=1:
  - latch N = i_out_w*i_out_h as a 32-bit product.
  - If N > 2^AW: N = 2^AW and o_clamped=1; otherwise o_clamped=0.
  - Clear accumulators; clear o_valid.
  - N==0 goes to DONE, else SCAN.
- SCAN: mem_raddr = addr, starting at 0 and incrementing each cycle. Advance to DRAIN after issuing N-1.
- Accumulation: a 1-cycle delayed valid tags each returned byte b.
  - sum += b
  - min/max update
  - count += 1
  - s1 = (s1+b) mod 65535
  - s2 = (s2+s1_new) mod 65535
  - Modulo is done by conditional subtract of 65535; both s1 and s2 are kept < 65535.
- DRAIN: absorbs the last byte, then goes to DONE.
- DONE: o_done=1 for one cycle, o_valid=1, back to IDLE.
- Latency: with start sampled at cycle 0, o_done is high at cycle N+2 (N>0) or cycle 1 (N==0).
- o_busy = o_port_busy = (state != IDLE).
- Outside IDLE, mem_raddr is the scan address.
- Empty image: count=0, sum=0, min=FF, max=00, csum=0.
- start while busy: ignored; the scan in progress is unaffected.
- start in the same cycle as DONE: ignored; the next start must come in a later cycle.
- Results hold until the next accepted start.
- rst_n asserted mid-scan: immediate return to reset values; no done pulse.
- sum cannot overflow: 4096*255 < 2^32.

Optional Feature:
STATS_HIST_EN
- Defined:
  - 16 bins indexed by b[7:4], each incremented per byte and saturating at all-ones.
  - Bins are cleared on accepted start.
  - o_hist_bin = bin[i_hist_sel], registered, 1-cycle latency.
- Undefined: no bin storage; o_hist_bin tied 0; i_hist_sel ignored.

Test Plan:
- 4x4 ramp 0..15, start -> o_done at cycle 18; count=16, sum=120, min=0, max=15, csum=32'h02A8_0078; hist bin0=16 (if enabled).
- i_out_w=0, i_out_h=64, start -> o_done at cycle 1; count=0, sum=0, min=FF, max=00, csum=0, o_valid=1, mem_raddr never leaves jtag_raddr.
- 128x64 with all pixels 0xFF -> o_clamped=1, count=4096, sum=1044480, s1 (csum[15:0])=61455, min=max=FF; hist bin15=4096 (if enabled).
- Start pulse again at mid-scan cycle 5 of a 4x4 -> ignored; results identical to first case; exactly one o_done.
- rst_n low at cycle 7 of a 4x4 scan -> all outputs at reset values, o_min=FF, no o_done; a subsequent start completes normally.
- Idle passthrough: jtag_raddr=0x123 -> mem_raddr=0x123, o_port_busy=0. During scan: mem_raddr tracks the scan address and o_port_busy=1.

Source files
------------

// File: rtl/out_scan_stats.sv
// Output-image scanner: after core done, reads the output BRAM once and produces
// count/sum/min/max/Fletcher-32. Optional 16-bin histogram under `STATS_HIST_EN.
module out_scan_stats #(
    parameter int AW         = 12,
    parameter int HIST_CNT_W = 16
) (
    input  logic                  clk_50,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [15:0]           i_out_w,
    input  logic [15:0]           i_out_h,
    input  logic [AW-1:0]         jtag_raddr,
    output logic [AW-1:0]         mem_raddr,
    input  logic [7:0]            mem_rdata,
    output logic                  o_port_busy,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_valid,
    output logic                  o_clamped,
    output logic [AW:0]           o_count,
    output logic [31:0]           o_sum,
    output logic [7:0]            o_min,
    output logic [7:0]            o_max,
    output logic [31:0]           o_csum,
    input  logic [3:0]            i_hist_sel,
    output logic [HIST_CNT_W-1:0] o_hist_bin
);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    localparam logic [31:0] MAX_PIX = 32'd1 << AW;
    localparam logic [16:0] MOD     = 17'd65535;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW:0]   n_q, n_d, n_m1;
    logic          rd_vld_q, rd_vld_d;
    logic          valid_q, valid_d;
    logic          clamped_q, clamped_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;
    logic [AW:0]   count_q, count_d;
    logic [31:0]   sum_q, sum_d;
    logic [7:0]    min_q, min_d, max_q, max_d;
    logic [15:0]   s1_q, s1_d, s2_q, s2_d;
    logic [31:0]   prod;
    logic          accept;
    logic [16:0]   s1_sum, s1_new, s2_sum, s2_new;

    assign prod   = 32'(i_out_w) * 32'(i_out_h);
    assign accept = (state_q == IDLE) && start;
    assign n_m1   = n_q - (AW+1)'(1);

    // Both Fletcher sums stay below 65535, so one conditional subtract suffices.
    assign s1_sum = {1'b0, s1_q} + {9'd0, mem_rdata};
    assign s1_new = (s1_sum >= MOD) ? s1_sum - MOD : s1_sum;
    assign s2_sum = {1'b0, s2_q} + s1_new;
    assign s2_new = (s2_sum >= MOD) ? s2_sum - MOD : s2_sum;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        n_d       = n_q;
        rd_vld_d  = (state_q == SCAN);
        valid_d   = valid_q;
        clamped_d = clamped_q;
        count_d   = count_q;
        sum_d     = sum_q;
        min_d     = min_q;
        max_d     = max_q;
        s1_d      = s1_q;
        s2_d      = s2_q;

        if (rd_vld_q) begin
            count_d = count_q + (AW+1)'(1);
            sum_d   = sum_q + {24'd0, mem_rdata};
            if (mem_rdata < min_q) min_d = mem_rdata;
            if (mem_rdata > max_q) max_d = mem_rdata;
            s1_d    = s1_new[15:0];
            s2_d    = s2_new[15:0];
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    clamped_d = (prod > MAX_PIX);
                    n_d       = (prod > MAX_PIX) ? MAX_PIX[AW:0] : prod[AW:0];
                    count_d   = '0;
                    sum_d     = '0;
                    min_d     = 8'hFF;
                    max_d     = '0;
                    s1_d      = '0;
                    s2_d      = '0;
                    if (prod == 32'd0) begin
                        // Empty image: keep the read port on the JTAG address.
                        state_d = DONE;
                        valid_d = 1'b1;
                        addr_d  = jtag_raddr;
                    end else begin
                        state_d = SCAN;
                        valid_d = 1'b0;
                        addr_d  = '0;
                    end
                end
            end
            SCAN: begin
                if ({1'b0, addr_q} == n_m1) state_d = DRAIN;
                else                        addr_d  = addr_q + AW'(1);
            end
            DRAIN: begin
                state_d = DONE;
                valid_d = 1'b1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign done_d = (state_d == DONE);
    assign busy_d = (state_d != IDLE);

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            n_q       <= '0;
            rd_vld_q  <= 1'b0;
            valid_q   <= 1'b0;
            clamped_q <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            count_q   <= '0;
            sum_q     <= '0;
            min_q     <= 8'hFF;
            max_q     <= '0;
            s1_q      <= '0;
            s2_q      <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            n_q       <= n_d;
            rd_vld_q  <= rd_vld_d;
            valid_q   <= valid_d;
            clamped_q <= clamped_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            count_q   <= count_d;
            sum_q     <= sum_d;
            min_q     <= min_d;
            max_q     <= max_d;
            s1_q      <= s1_d;
            s2_q      <= s2_d;
        end
    end

    assign mem_raddr   = (state_q == IDLE) ? jtag_raddr : addr_q;
    assign o_port_busy = busy_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_valid     = valid_q;
    assign o_clamped   = clamped_q;
    assign o_count     = count_q;
    assign o_sum       = sum_q;
    assign o_min       = min_q;
    assign o_max       = max_q;
    assign o_csum      = {s2_q, s1_q};

`ifdef STATS_HIST_EN
    logic [15:0][HIST_CNT_W-1:0] hist_q, hist_d;
    logic [HIST_CNT_W-1:0]       hist_bin_q;

    always_comb begin
        hist_d = hist_q;
        if (accept)
            hist_d = '0;
        else if (rd_vld_q && (hist_q[mem_rdata[7:4]] != '1))
            hist_d[mem_rdata[7:4]] = hist_q[mem_rdata[7:4]] + HIST_CNT_W'(1);
    end

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            hist_q     <= '0;
            hist_bin_q <= '0;
        end else begin
            hist_q     <= hist_d;
            hist_bin_q <= hist_q[i_hist_sel];
        end
    end

    assign o_hist_bin = hist_bin_q;
`else
    logic hist_sel_unused;
    assign hist_sel_unused = ^i_hist_sel;
    assign o_hist_bin      = '0;
`endif

endmodule

// File: tb/tb_out_scan_stats.sv
// Scoreboard bench for out_scan_stats: stimulus pushes model results, a monitor
// pops and compares on every o_done.
module tb_out_scan_stats;
    localparam int AW = 12;
    localparam int HW = 16;

    logic          clk_50 = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [15:0]   i_out_w = '0, i_out_h = '0;
    logic [AW-1:0] jtag_raddr = '0;
    logic [AW-1:0] mem_raddr;
    logic [7:0]    mem_rdata = '0;
    logic          o_port_busy, o_busy, o_done, o_valid, o_clamped;
    logic [AW:0]   o_count;
    logic [31:0]   o_sum, o_csum;
    logic [7:0]    o_min, o_max;
    logic [3:0]    i_hist_sel = '0;
    logic [HW-1:0] o_hist_bin;

    out_scan_stats #(.AW(AW), .HIST_CNT_W(HW)) dut (
        .clk_50(clk_50), .rst_n(rst_n), .start(start),
        .i_out_w(i_out_w), .i_out_h(i_out_h), .jtag_raddr(jtag_raddr),
        .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
        .o_port_busy(o_port_busy), .o_busy(o_busy), .o_done(o_done),
        .o_valid(o_valid), .o_clamped(o_clamped), .o_count(o_count),
        .o_sum(o_sum), .o_min(o_min), .o_max(o_max), .o_csum(o_csum),
        .i_hist_sel(i_hist_sel), .o_hist_bin(o_hist_bin)
    );

    always #10 clk_50 = ~clk_50;

    int cyc = 0;
    always @(posedge clk_50) cyc <= cyc + 1;

    logic [7:0] mem [0:4095];
    always @(posedge clk_50) mem_rdata <= mem[mem_raddr];

    typedef struct {
        int          done_cyc;
        logic [AW:0] cnt;
        logic [31:0] sum;
        logic [7:0]  mn;
        logic [7:0]  mx;
        logic [31:0] csum;
        logic        clamped;
    } exp_t;

    exp_t sb[$];
    int   checks = 0, failures = 0, done_cnt = 0;
    int   exp_hist[16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: straight from the rules, using % for the Fletcher modulus.
    task automatic model(input int w, input int h, output exp_t e, output int n);
        longint p;
        int s1, s2, b;
        p = longint'(w) * longint'(h);
        n = (p > 4096) ? 4096 : int'(p);
        e.clamped = (p > 4096);
        e.cnt = n[AW:0];
        e.sum = 0; e.mn = 8'hFF; e.mx = 8'h00;
        s1 = 0; s2 = 0;
        for (int i = 0; i < 16; i++) exp_hist[i] = 0;
        for (int i = 0; i < n; i++) begin
            b = int'(mem[i]);
            e.sum += 32'(b);
            if (b < int'(e.mn)) e.mn = 8'(b);
            if (b > int'(e.mx)) e.mx = 8'(b);
            s1 = (s1 + b) % 65535;
            s2 = (s2 + s1) % 65535;
            if (exp_hist[b / 16] < (1 << HW) - 1) exp_hist[b / 16]++;
        end
        e.csum = 32'(s2) * 32'd65536 + 32'(s1);
        e.done_cyc = 0;
    endtask

    always @(negedge clk_50) begin
        if (rst_n && o_done) begin
            exp_t e;
            done_cnt++;
            if (sb.size() == 0) chk("unexpected_done", 1, 0);
            else begin
                e = sb.pop_front();
                chk("done_cycle", 64'(cyc), 64'(e.done_cyc));
                chk("count", o_count, e.cnt);
                chk("sum", o_sum, e.sum);
                chk("min", o_min, e.mn);
                chk("max", o_max, e.mx);
                chk("csum", o_csum, e.csum);
                chk("clamped", o_clamped, e.clamped);
                chk("valid", o_valid, 1);
            end
        end
    end

    task automatic check_reset();
        chk("rst_busy", o_busy, 0);
        chk("rst_port_busy", o_port_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_valid", o_valid, 0);
        chk("rst_clamped", o_clamped, 0);
        chk("rst_count", o_count, 0);
        chk("rst_sum", o_sum, 0);
        chk("rst_min", o_min, 8'hFF);
        chk("rst_max", o_max, 0);
        chk("rst_csum", o_csum, 0);
        chk("rst_raddr", mem_raddr, jtag_raddr);
    endtask

    task automatic run_scan(input int w, input int h, input int restart);
        exp_t e;
        int s, n, d0;
        model(w, h, e, n);
        @(posedge clk_50); #1;
        i_out_w = 16'(w); i_out_h = 16'(h); start = 1'b1;
        s = cyc;
        e.done_cyc = s + ((n == 0) ? 1 : n + 2);
        sb.push_back(e);
        d0 = done_cnt;
        @(posedge clk_50); #1 start = 1'b0;
        @(negedge clk_50);
        chk("busy_in_scan", o_busy, 1);
        chk("port_busy_in_scan", o_port_busy, 1);
        if (n == 0) chk("raddr_empty", mem_raddr, jtag_raddr);
        else        chk("raddr_scan0", mem_raddr, 0);
        if (n >= 3) begin
            @(negedge clk_50); @(negedge clk_50);
            chk("raddr_scan2", mem_raddr, 2);
        end
        if (restart > 0) begin
            while (cyc < s + restart) begin @(posedge clk_50); #1; end
            i_out_w = 16'd9; start = 1'b1;
            @(posedge clk_50); #1 start = 1'b0;
        end
        for (int k = 0; k < n + 20 && sb.size() != 0; k++) @(posedge clk_50);
        chk("scan_timeout", 64'(sb.size()), 0);
        sb.delete();
        repeat (3) @(negedge clk_50);
        chk("one_done", 64'(done_cnt - d0), 1);
        chk("idle_after", o_busy, 0);
`ifdef STATS_HIST_EN
        for (int b = 0; b < 16; b++) begin
            @(posedge clk_50); #1 i_hist_sel = 4'(b);
            @(posedge clk_50); #1;
            chk("hist_bin", o_hist_bin, 64'(exp_hist[b]));
        end
`endif
    endtask

    initial begin
        exp_t e;
        int s, n, d0;
        for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
        jtag_raddr = 12'h123;
        repeat (3) @(posedge clk_50); #1;
        check_reset();
        rst_n = 1'b1;
        @(negedge clk_50);
        chk("idle_passthru", mem_raddr, 12'h123);
        chk("idle_port_busy", o_port_busy, 0);

        // 4x4 ramp
        for (int i = 0; i < 4096; i++) mem[i] = 8'(i);
        run_scan(4, 4, 0);
        chk("ramp_sum", o_sum, 120);
        chk("ramp_csum", o_csum, 32'h02A8_0078);
        chk("ramp_hold_valid", o_valid, 1);

        // empty image
        run_scan(0, 64, 0);
        chk("empty_min", o_min, 8'hFF);
        chk("empty_max", o_max, 0);

        // clamped all-FF
        for (int i = 0; i < 4096; i++) mem[i] = 8'hFF;
        run_scan(128, 64, 0);
        chk("clamp_flag", o_clamped, 1);
        chk("clamp_s1", o_csum[15:0], 61455);
        chk("clamp_sum", o_sum, 1044480);

        // restart pulse mid-scan is ignored
        for (int i = 0; i < 4096; i++) mem[i] = 8'(i);
        run_scan(4, 4, 5);
        chk("restart_csum", o_csum, 32'h02A8_0078);

        // reset mid-scan
        model(4, 4, e, n);
        @(posedge clk_50); #1;
        i_out_w = 16'd4; i_out_h = 16'd4; start = 1'b1;
        s = cyc; e.done_cyc = s + n + 2; sb.push_back(e); d0 = done_cnt;
        @(posedge clk_50); #1 start = 1'b0;
        while (cyc < s + 7) begin @(posedge clk_50); #1; end
        rst_n = 1'b0;
        sb.delete();
        #1 check_reset();
        @(posedge clk_50); #1 rst_n = 1'b1;
        repeat (25) @(negedge clk_50);
        chk("no_done_after_rst", 64'(done_cnt - d0), 0);
        run_scan(4, 4, 0);

        // randomized sizes and contents
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
            run_scan(int'($urandom_range(0, 24)), int'($urandom_range(0, 24)), 0);
        end
        for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
        run_scan(70, 70, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
